traffic_sensor_conditioner: RTL and testbench

TRAFFIC_SENSOR_CONDITIONER -- requirements
Module: traffic_sensor_conditioner

---
 rtl/traffic_sensor_conditioner.sv | 148 ++++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner
// Input conditioning for the farm-road traffic controller:
//   - debounces the raw farm-road car sensor (C_raw -> C)
//   - latches siren-detector requests into a registered Emergency level
//     that stays up until the farm road goes green (FG) or a timeout expires
//   - counts served emergencies (saturating) and flags unserved ones (sticky)
// Optional feature: define TRAFFIC_SENSOR_EMG_HOLDOFF_EN to add a holdoff
// window after each clear, during which new requests are dropped.
// The emergency FSM state is exported on emg_state for observation
// (0 = idle, 1 = active, 2 = holdoff).
// Handshake: there is no valid/ready handshake here. EmgReq is a plain level
// sampled on every rising edge, and FG is a plain level acknowledging service.
module traffic_sensor_conditioner #(
    parameter int DEBOUNCE    = 4,
    parameter int EMG_TIMEOUT = 32,
    parameter int HOLDOFF     = 8
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       C_raw,
    input  logic       EmgReq,
    input  logic       FG,
    output logic       C,
    output logic       Emergency,
    output logic       EmgFault,
    output logic [7:0] EmgCount,
    output logic [1:0] emg_state
);

    // Reject parameter values outside their supported ranges at elaboration.
    if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
        $error("DEBOUNCE must be in 1..15");
    end
    if (EMG_TIMEOUT < 2 || EMG_TIMEOUT > 255) begin : g_bad_timeout
        $error("EMG_TIMEOUT must be in 2..255");
    end
    if (HOLDOFF < 1 || HOLDOFF > 255) begin : g_bad_holdoff
        $error("HOLDOFF must be in 1..255");
    end

    localparam logic [3:0] DB_LAST  = 4'(DEBOUNCE - 1);
    localparam logic [7:0] TMO_LAST = 8'(EMG_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
`ifdef TRAFFIC_SENSOR_EMG_HOLDOFF_EN
        ST_HOLDOFF = 2'd2,
`endif
        ST_ACTIVE  = 2'd1
    } state_t;

    state_t     state;
    logic [3:0] db_cnt;
    logic [7:0] tmo_cnt;

`ifdef TRAFFIC_SENSOR_EMG_HOLDOFF_EN
    localparam logic [7:0] HO_LAST = 8'(HOLDOFF - 1);
    logic [7:0] ho_cnt;
`endif

    assign emg_state = state;

    // Debounce: C follows C_raw only after DEBOUNCE consecutive differing edges.
    always_ff @(posedge Clk) begin
        if (reset) begin
            C      <= 1'b0;
            db_cnt <= 4'd0;
        end else if (C_raw == C) begin
            db_cnt <= 4'd0;
        end else if (db_cnt == DB_LAST) begin
            C      <= C_raw;
            db_cnt <= 4'd0;
        end else begin
            db_cnt <= db_cnt + 4'd1;
        end
    end

    // Emergency FSM: latch a request, clear on service (FG) or on timeout.
    // A request sampled on the clearing edge is always dropped. With holdoff
    // enabled, Emergency stays low for exactly HOLDOFF cycles after a clear;
    // the edge that ends the last holdoff cycle already accepts a request,
    // so a held request reasserts Emergency HOLDOFF cycles after the clear.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            Emergency <= 1'b0;
            EmgFault  <= 1'b0;
            EmgCount  <= 8'd0;
            tmo_cnt   <= 8'd0;
`ifdef TRAFFIC_SENSOR_EMG_HOLDOFF_EN
            ho_cnt    <= 8'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (EmgReq) begin
                        state     <= ST_ACTIVE;
                        Emergency <= 1'b1;
                        tmo_cnt   <= 8'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (FG || tmo_cnt == TMO_LAST) begin
                        Emergency <= 1'b0;
                        tmo_cnt   <= 8'd0;
                        if (FG) begin
                            // Served, even when it lands on the timeout edge.
                            if (EmgCount != 8'hFF) begin
                                EmgCount <= EmgCount + 8'd1;
                            end
                        end else begin
                            EmgFault <= 1'b1;
                        end
`ifdef TRAFFIC_SENSOR_EMG_HOLDOFF_EN
                        state  <= ST_HOLDOFF;
                        ho_cnt <= 8'd0;
`else
                        state  <= ST_IDLE;
`endif
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
`ifdef TRAFFIC_SENSOR_EMG_HOLDOFF_EN
                ST_HOLDOFF: begin
                    if (ho_cnt == HO_LAST) begin
                        ho_cnt <= 8'd0;
                        if (EmgReq) begin
                            state     <= ST_ACTIVE;
                            Emergency <= 1'b1;
                            tmo_cnt   <= 8'd0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        ho_cnt <= ho_cnt + 8'd1;
                    end
                end
`endif
                default: begin
                    state     <= ST_IDLE;
                    Emergency <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner (default parameters).
// Expectations follow TRAFFIC_SENSOR_EMG_HOLDOFF_EN when it is defined.
module tb_traffic_sensor_conditioner;

    logic       Clk = 1'b0;
    logic       reset;
    logic       C_raw;
    logic       EmgReq;
    logic       FG;
    logic       C;
    logic       Emergency;
    logic       EmgFault;
    logic [7:0] EmgCount;
    logic [1:0] emg_state;

    int tests = 0;
    int fails = 0;

    traffic_sensor_conditioner dut (
        .Clk       (Clk),
        .reset     (reset),
        .C_raw     (C_raw),
        .EmgReq    (EmgReq),
        .FG        (FG),
        .C         (C),
        .Emergency (Emergency),
        .EmgFault  (EmgFault),
        .EmgCount  (EmgCount),
        .emg_state (emg_state)
    );

    // clock
    always #5 Clk = ~Clk;

    // advance one rising edge, then settle 1 time unit past it
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // wait out a possible holdoff window so the FSM is idle again
    task automatic settle();
        repeat (10) step();
    endtask

    initial begin
        reset = 1'b1; C_raw = 1'b0; EmgReq = 1'b0; FG = 1'b0;
        step(); step();
        chk("rst_c", C, 0);
        chk("rst_emg", Emergency, 0);
        chk("rst_fault", EmgFault, 0);
        chk("rst_count", EmgCount, 0);
        chk("rst_state", emg_state, 0);
        reset = 1'b0;

        // debounce: 0->1 held, C rises on the 4th edge
        C_raw = 1'b1;
        repeat (3) step();
        chk("db_rise_early", C, 0);
        step();
        chk("db_rise", C, 1);
        // 3-cycle low glitch is ignored
        C_raw = 1'b0;
        repeat (3) step();
        C_raw = 1'b1;
        step();
        chk("db_glitch_low", C, 1);
        // 1->0 held
        C_raw = 1'b0;
        repeat (3) step();
        chk("db_fall_early", C, 1);
        step();
        chk("db_fall", C, 0);
        // 3-cycle high pulse is ignored
        C_raw = 1'b1;
        repeat (3) step();
        C_raw = 1'b0;
        repeat (3) step();
        chk("db_pulse", C, 0);

        // served emergency
        EmgReq = 1'b1;
        step();
        chk("srv_rise", Emergency, 1);
        chk("srv_state", emg_state, 1);
        EmgReq = 1'b0;
        repeat (4) step();
        chk("srv_hold", Emergency, 1);
        FG = 1'b1;
        step();
        chk("srv_fall", Emergency, 0);
        chk("srv_count", EmgCount, 1);
        chk("srv_fault", EmgFault, 0);
        FG = 1'b0;
        settle();

        // request held through a clear
        EmgReq = 1'b1;
        step();
        chk("held_rise", Emergency, 1);
        repeat (2) step();
        FG = 1'b1;
        step();
        FG = 1'b0;
        chk("held_clear", Emergency, 0);
        chk("held_count", EmgCount, 2);
`ifdef TRAFFIC_SENSOR_EMG_HOLDOFF_EN
        repeat (7) step();
        chk("held_holdoff_low", Emergency, 0);
        chk("held_holdoff_state", emg_state, 2);
        step();
        chk("held_reassert", Emergency, 1);
`else
        step();
        chk("held_reassert", Emergency, 1);
`endif
        EmgReq = 1'b0;
        FG = 1'b1;
        step();
        FG = 1'b0;
        chk("held_count2", EmgCount, 3);
        settle();

        // timeout with FG low
        EmgReq = 1'b1;
        step();
        EmgReq = 1'b0;
        chk("tmo_rise", Emergency, 1);
        repeat (31) step();
        chk("tmo_still_high", Emergency, 1);
        chk("tmo_no_fault_yet", EmgFault, 0);
        step();
        chk("tmo_fall", Emergency, 0);
        chk("tmo_fault", EmgFault, 1);
        chk("tmo_count", EmgCount, 3);
        // FG while not active has no effect
        FG = 1'b1;
        repeat (3) step();
        FG = 1'b0;
        chk("fg_idle_count", EmgCount, 3);
        chk("fg_idle_emg", Emergency, 0);
        settle();

        // FG on the timeout edge counts as served
        EmgReq = 1'b1;
        step();
        EmgReq = 1'b0;
        repeat (31) step();
        FG = 1'b1;
        step();
        FG = 1'b0;
        chk("tmo_fg_fall", Emergency, 0);
        chk("tmo_fg_count", EmgCount, 4);
        chk("fault_sticky", EmgFault, 1);
        settle();

        // reset mid-active
        C_raw = 1'b1;
        repeat (4) step();
        chk("pre_rst_c", C, 1);
        EmgReq = 1'b1;
        step();
        chk("pre_rst_emg", Emergency, 1);
        reset = 1'b1;
        C_raw = 1'b0;
        step();
        chk("mid_rst_emg", Emergency, 0);
        chk("mid_rst_fault", EmgFault, 0);
        chk("mid_rst_c", C, 0);
        chk("mid_rst_count", EmgCount, 0);
        chk("mid_rst_state", emg_state, 0);
        // request held across reset release is taken on the first free edge
        reset = 1'b0;
        step();
        chk("post_rst_accept", Emergency, 1);
        EmgReq = 1'b0;
        FG = 1'b1;
        step();
        FG = 1'b0;
        chk("post_rst_count", EmgCount, 1);
        settle();

        // saturation: 254 more served -> 255, then one more stays 255
        for (int i = 0; i < 254; i++) begin
            EmgReq = 1'b1;
            step();
            EmgReq = 1'b0;
            FG = 1'b1;
            step();
            FG = 1'b0;
`ifdef TRAFFIC_SENSOR_EMG_HOLDOFF_EN
            repeat (8) step();
`endif
        end
        chk("sat_255", EmgCount, 255);
        EmgReq = 1'b1;
        step();
        chk("sat_active", Emergency, 1);
        EmgReq = 1'b0;
        FG = 1'b1;
        step();
        FG = 1'b0;
        chk("sat_hold", EmgCount, 255);
        chk("sat_fault", EmgFault, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
